// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Two-digit BCD down-counter with a programmable prescaler and a
// start/pause/abort control FSM. Loads a 00-99 BCD preset, decrements once
// every PRESCALE clocks with decade borrow, and pulses done on reaching 00.
module bcd_countdown_timer #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [7:0] count,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          load_ok;
    logic          tick;
    logic [7:0]    dec_val;

    assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign tick    = (presc_q == PRE_LAST);

    // One-step BCD decrement with decade borrow (x0 -> (x-1)9)
    always_comb begin
        if (count_q[3:0] != 4'd0) begin
            dec_val = {count_q[7:4], count_q[3:0] - 4'd1};
        end else begin
            dec_val = {count_q[7:4] - 4'd1, 4'd9};
        end
    end

    // Next-state logic: abort > load > start > pause > decrement
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        if (load_ok) begin
                            count_d = load_val;
                            err_d   = 1'b0;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end else if (start) begin
                        presc_d = '0;
                        if (count_q != 8'h00) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    // Leaving PAUSED counts this cycle too, so each paused
                    // cycle costs exactly one cycle of extra latency.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_RUN;
                        if (tick) begin
                            presc_d = '0;
                            count_d = dec_val;
                            if (dec_val == 8'h00) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (load) begin
                        state_d = ST_IDLE;
                        if (load_ok) begin
                            count_d = load_val;
                            err_d   = 1'b0;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign state    = state_q;
    assign running  = (state_q == ST_RUN);
    assign done     = done_q;
    assign load_err = err_q;

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Two-digit BCD down-counter with a programmable prescaler and a start/pause/abort control FSM. It is the count-down counterpart to the team's decade up-counter. It loads a preset in 00–99 BCD, decrements once every PRESCALE clocks with correct decade borrow (x0 → (x-1)9), and flags terminal count with a one-cycle `done` pulse. It serves as the timeout/interval source for lab sequencing designs.

## Interface
- PRESCALE, default 4: number of clk cycles per count decrement; legal range ≥ 1.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  capture `load_val`; honoured only in IDLE and DONE.
- load_val  in  8  preset as {tens[7:4], ones[3:0]}, BCD.
- start  in  1  begin counting; honoured only in IDLE.
- pause  in  1  level; while high in RUN or PAUSED, counting is frozen.
- abort  in  1  return to IDLE from any state and clear the count.
- count  out  8  current value, BCD {tens, ones}.
- state  out  2  IDLE=00, RUN=01, PAUSED=10, DONE=11.
- running  out  1  high iff state==RUN.
- done  out  1  one-cycle pulse on reaching 00 from a running count.
- load_err  out  1  sticky; set by a load with an invalid nibble (>9), cleared by the next valid load or by abort.

## Operation
- Reset (async): state=IDLE, count=8'h00, prescaler=0, done=0, load_err=0, running=0.
- Priority, per edge: rst > abort > load > start > pause > decrement.
- abort, any state: state←IDLE, count←00, prescaler←0, load_err←0, no done pulse.
- IDLE:
  - Valid load (both nibbles ≤9): count←load_val, load_err←0.
  - Invalid load: count unchanged, load_err←1.
  - If load and start are high in the same cycle, start is ignored.
  - start with count≠00: state←RUN, prescaler←0.
  - start with count==00: state←DONE, done pulses; no RUN cycle.
- RUN:
  - pause high: state←PAUSED, prescaler and count hold. pause also wins over a same-cycle terminal prescale tick, so no decrement occurs that cycle.
  - Otherwise the prescaler increments. When prescaler==PRESCALE-1 it wraps to 0 and count decrements:
    - ones≠0: ones−1.
    - ones==0: ones←9, tens−1.
  - A decrement that yields 00 sets state←DONE and done=1 on the same edge.
  - load and start are ignored.
- PAUSED: pause low → RUN, with the prescaler resuming from its frozen value. load and start are ignored.
- DONE:
  - count holds 00; done is high only on the entry edge.
  - Any load → IDLE. A valid load sets count; an invalid load sets load_err and count stays 00.
  - start without load is ignored.
- Width/arithmetic:
  - Prescaler width is clog2(PRESCALE), minimum 1 bit. PRESCALE=1 decrements every RUN cycle.
  - count never holds a non-BCD value.
  - No underflow below 00 occurs: DONE is entered first.

## Timing
- All outputs are registered; `running` and `state` are decoded from the state register only.
- Load latency: a load sampled at edge E is visible on count after E.
- Start latency: start sampled at edge E → RUN after E. The first decrement occurs at edge E+PRESCALE.
- From preset N (decimal) with no pause, done is asserted after edge E+N·PRESCALE, coincident with count==00, and lasts exactly 1 cycle.
- Each pause cycle in RUN or PAUSED extends the done time by 1 cycle.
- Reset mid-count: outputs go to reset values immediately (async). The first action after deassertion requires a new load/start.

## Test plan
- Reset/IDLE:
  - Stimulus: reset, then load 8'h25, then start, with PRESCALE=4.
  - Required: count 25→24 at the 4th edge after start. done pulses exactly once, 100 edges after start, with count=00 and state=DONE.
- Decade borrow:
  - Stimulus: load 8'h10, start, with PRESCALE=1.
  - Required: count sequence 10, 09, 08 … 01, 00. No A–F nibble ever appears. done is high for 1 cycle, 10 edges after start.
- Pause:
  - Stimulus: load 8'h03, start (PRESCALE=4), then pause held for 7 cycles starting 2 edges after start.
  - Required: count and prescaler frozen during the pause. done arrives 19 edges after start.
- Invalid load:
  - Stimulus: load 8'h3A in IDLE.
  - Required: load_err=1, count unchanged. A following load of 8'h12 clears load_err and sets count=12.
- Abort/reset mid-run:
  - Stimulus: abort during RUN at count 07.
  - Required: next edge gives state=IDLE, count=00, no done pulse.
  - Stimulus: async rst mid-run.
  - Required: immediate reset values.
- Edge cases:
  - Start with count 00 → DONE with a 1-cycle done pulse.
  - load+start in the same cycle in IDLE → load applied, state stays IDLE.
  - load in DONE → IDLE with the new count.
